// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: alignment check, one 8-byte-aligned memory transaction, offset-aligned load data.
// Optional response watchdog enabled by defining LSU_RSP_TIMEOUT_EN.
module lsu_mem_ctrl #(
    parameter int ADDR_W      = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [63:0]       mem_rdata,
    output logic              done_valid,
    output logic [63:0]       done_mrd,
    output logic [2:0]        done_func3,
    output logic              done_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef struct packed {
        logic       wen;
        logic [2:0] func3;
        logic [2:0] off;
    } req_t;

    logic [1:0]        state;
    req_t              cap;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_wen_q;
    logic [63:0]       mem_wdata_q;
    logic [7:0]        mem_wmask_q;
    logic [63:0]       done_mrd_q;
    logic [2:0]        done_func3_q;
    logic              done_err_q;

`ifdef LSU_RSP_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] cnt;
`endif

    logic        misal;
    logic        illegal;
    logic [7:0]  st_wmask;
    logic [63:0] st_wdata;

    always_comb begin
        misal    = 1'b0;
        st_wmask = 8'hFF;
        case (req_func3[1:0])
            2'd0: begin misal = 1'b0;                   st_wmask = 8'h01 << req_addr[2:0]; end
            2'd1: begin misal = req_addr[0];            st_wmask = 8'h03 << req_addr[2:0]; end
            2'd2: begin misal = |req_addr[1:0];         st_wmask = 8'h0F << req_addr[2:0]; end
            default: begin misal = |req_addr[2:0];      st_wmask = 8'hFF; end
        endcase
        illegal  = (req_wen && req_func3[2]) || (!req_wen && req_func3 == 3'b111);
        st_wdata = req_wdata << {req_addr[2:0], 3'b000};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cap          <= '0;
            mem_addr_q   <= '0;
            mem_wen_q    <= 1'b0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            done_mrd_q   <= '0;
            done_func3_q <= '0;
            done_err_q   <= 1'b0;
`ifdef LSU_RSP_TIMEOUT_EN
            cnt          <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    cap.wen   <= req_wen;
                    cap.func3 <= req_func3;
                    cap.off   <= req_addr[2:0];
                    if (misal || illegal) begin
                        // rejected ops complete without touching the memory bus
                        state        <= S_DONE;
                        done_err_q   <= 1'b1;
                        done_mrd_q   <= '0;
                        done_func3_q <= req_func3;
                    end else begin
                        state       <= S_REQ;
                        mem_addr_q  <= {req_addr[ADDR_W-1:3], 3'b000};
                        mem_wen_q   <= req_wen;
                        mem_wdata_q <= req_wen ? st_wdata : 64'd0;
                        mem_wmask_q <= req_wen ? st_wmask : 8'd0;
                    end
                end
                S_REQ: if (mem_req_ready) begin
                    state <= S_WAIT;
`ifdef LSU_RSP_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        state        <= S_DONE;
                        done_mrd_q   <= cap.wen ? 64'd0 : (mem_rdata >> {cap.off, 3'b000});
                        done_err_q   <= 1'b0;
                        done_func3_q <= cap.func3;
                    end
`ifdef LSU_RSP_TIMEOUT_EN
                    // a response in the final cycle takes priority over the watchdog
                    else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state        <= S_DONE;
                        done_mrd_q   <= '0;
                        done_err_q   <= 1'b1;
                        done_func3_q <= cap.func3;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = (state == S_IDLE);
    assign mem_req_valid = (state == S_REQ);
    assign mem_addr      = mem_addr_q;
    assign mem_wen       = mem_wen_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;
    assign done_valid    = (state == S_DONE);
    assign done_mrd      = done_mrd_q;
    assign done_func3    = done_func3_q;
    assign done_err      = done_err_q;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store memory controller that sits directly upstream of the load sign/zero-extension stage in the RV64 core.
- Accepts one load or store from the execute stage and checks alignment.
- Issues a single 8-byte-aligned transaction on the data-memory valid/ready bus and waits for the response.
- For loads, delivers the raw 64-bit word right-shifted by the byte offset (done_mrd) plus func3; the extension stage consumes both.

Parameters:
- ADDR_W, 64, width of request and memory addresses.
- TIMEOUT_CYC, 255, watchdog limit in cycles for the response wait; used only when LSU_RSP_TIMEOUT_EN is defined.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  execute stage presents a memory op.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_wen  in  1  1 = store, 0 = load.
- req_func3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  64  store data, LSB-aligned.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  ADDR_W  request address with bits [2:0] forced to 0.
- mem_wen  out  1  write enable.
- mem_wdata  out  64  store data shifted to its byte lane.
- mem_wmask  out  8  byte-lane write mask.
- mem_rsp_valid  in  1  response or write acknowledge.
- mem_rdata  in  64  read data.
- done_valid  out  1  single-cycle completion pulse.
- done_mrd  out  64  aligned load data for the extension stage.
- done_func3  out  3  captured func3.
- done_err  out  1  misaligned/illegal (or timeout) flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state IDLE. Every output 0 except req_ready, which is 1. All internal registers cleared.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, capture wen, func3, addr, wdata and offset=addr[2:0].
  - Size = func3[1:0]. Misaligned when (size=1 and addr[0]) or (size=2 and addr[1:0]!=0) or (size=3 and addr[2:0]!=0).
  - Illegal when (store and func3[2]=1) or (load and func3=3'b111).
  - Misaligned or illegal: go to DONE with err=1 and no memory access. Otherwise go to REQ.
- REQ:
  - mem_req_valid=1. mem_addr, mem_wen, mem_wdata and mem_wmask are held stable until mem_req_ready.
  - On mem_req_ready, go to WAIT.
- Store byte lanes:
  - wdata = req_wdata << (offset*8).
  - wmask: sb=8'h01<<offset, sh=8'h03<<offset, sw=8'h0F<<offset, sd=8'hFF.
  - Loads drive wmask=0 and wdata=0.
- WAIT:
  - mem_rsp_valid is ignored in the same cycle as the REQ handshake; the earliest valid response is one cycle later.
  - On mem_rsp_valid: for a load, capture mem_rdata >> (offset*8); for a store (write ack), capture 0. Then go to DONE.
- DONE:
  - done_valid=1 for exactly one cycle; done_mrd, done_func3 and done_err are valid in the same cycle.
  - No backpressure. Always return to IDLE next cycle.
- Outside DONE, done_* outputs hold their last value and done_valid=0.
- Latency:
  - Accept at cycle T, memory ready in REQ at T+1, response at T+2 → done_valid at T+3.
  - Error path: done_valid at T+1.
- req_valid is never accepted outside IDLE, including in DONE.
- mem_rsp_valid outside WAIT is ignored, including a stale response arriving after a reset.
- Reset asserted mid-operation: immediate return to IDLE, outputs at reset values, request abandoned.

Optional Feature:
- Macro: LSU_RSP_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC without mem_rsp_valid, go to DONE with done_err=1 and done_mrd=0.
  - A response arriving in the same cycle as the timeout wins: normal completion, err=0.
- Undefined: no counter; WAIT lasts indefinitely.

Test Plan:
- lb, addr 0x80000003, mem_req_ready immediate, rsp one cycle later with rdata 0x1122334455667788 → mem_addr 0x80000000, mem_wen 0, done_mrd 0x0000001122334455, func3 000, err 0, done at T+3.
- sh, addr 0x80000006, wdata 0xABCD → mem_wmask 0xC0, mem_wdata 0xABCD000000000000, mem_wen 1; write ack → done_mrd 0, err 0.
- lw at 0x80000002, and separately sb with func3 100 → done_err 1 at T+1, mem_req_valid never asserted.
- ld at 0x80000008 with mem_req_ready low for 5 cycles → mem_req_valid and mem_addr stable all 5 cycles, req_ready 0; completes normally.
- rst_n pulsed low in WAIT, then mem_rsp_valid arrives after release → all outputs 0, req_ready 1, response ignored, no done_valid.
- LSU_RSP_TIMEOUT_EN with TIMEOUT_CYC=4 and no response → done_valid and done_err 1 after 4 WAIT cycles; response in the 4th cycle → err 0.
